// File: rtl/sc_rv32i_datapath.sv
// Single-cycle RV32I core that owns its PC, register file and instruction/data memories.
// Each instruction retires in one clk cycle; there is no stall path, so nothing can backpressure the core.

module sc_rv32i_reg_file (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] registers [0:31];

  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) registers[waddr] <= wdata;
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : registers[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : registers[raddr2];
endmodule

module sc_rv32i_mem #(
  parameter int unsigned DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] memory [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

  assign rdata = memory[addr];
endmodule

module sc_rv32i_datapath #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input  logic clk,
  input  logic reset
);
  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_dat, rs2_dat;
  logic [31:0] alu_b, alu_res;
  logic [2:0]  alu_f3;
  logic        alu_alt;
  logic [4:0]  shamt;
  logic        br_taken;
  logic [31:0] dmem_rdat;
  logic        rf_we, dmem_we;
  logic [31:0] wb_dat;

  sc_rv32i_mem #(.DEPTH(IMEM_DEPTH)) inst_mem_0 (
    .clk   (clk),
    .we    (1'b0),
    .addr  (pc_q[IMEM_AW+1:2]),
    .wdata (32'd0),
    .rdata (instr)
  );

  sc_rv32i_reg_file reg_file_0 (
    .clk    (clk),
    .we     (rf_we & ~reset),
    .waddr  (rd),
    .wdata  (wb_dat),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_dat),
    .rdata2 (rs2_dat)
  );

  sc_rv32i_mem #(.DEPTH(DMEM_DEPTH)) data_mem_0 (
    .clk   (clk),
    .we    (dmem_we & ~reset),
    .addr  (alu_res[DMEM_AW+1:2]),
    .wdata (rs2_dat),
    .rdata (dmem_rdat)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Loads, stores and jalr reuse the adder for rs1 + offset.
  always_comb begin
    alu_b   = imm_i;
    alu_f3  = 3'b000;
    alu_alt = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_b   = rs2_dat;
        alu_f3  = funct3;
        alu_alt = instr[30];
      end
      OPC_OP_IMM: begin
        alu_f3  = funct3;
        alu_alt = (funct3 == 3'b101) & instr[30];
      end
      OPC_STORE: alu_b = imm_s;
      default: ;
    endcase
  end

  assign shamt = alu_b[4:0];

  always_comb begin
    alu_res = 32'd0;
    case (alu_f3)
      3'b000: alu_res = alu_alt ? (rs1_dat - alu_b) : (rs1_dat + alu_b);
      3'b001: alu_res = rs1_dat << shamt;
      3'b010: alu_res = {31'd0, $signed(rs1_dat) < $signed(alu_b)};
      3'b011: alu_res = {31'd0, rs1_dat < alu_b};
      3'b100: alu_res = rs1_dat ^ alu_b;
      3'b101: alu_res = alu_alt ? 32'($signed(rs1_dat) >>> shamt) : (rs1_dat >> shamt);
      3'b110: alu_res = rs1_dat | alu_b;
      3'b111: alu_res = rs1_dat & alu_b;
      default: ;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000: br_taken = (rs1_dat == rs2_dat);
      3'b001: br_taken = (rs1_dat != rs2_dat);
      3'b100: br_taken = ($signed(rs1_dat) <  $signed(rs2_dat));
      3'b101: br_taken = ($signed(rs1_dat) >= $signed(rs2_dat));
      3'b110: br_taken = (rs1_dat <  rs2_dat);
      3'b111: br_taken = (rs1_dat >= rs2_dat);
      default: ;
    endcase
  end

  assign pc_plus4 = pc_q + 32'd4;

  // Unlisted opcodes fall through with no writes and a sequential PC.
  always_comb begin
    pc_d    = pc_plus4;
    rf_we   = 1'b0;
    dmem_we = 1'b0;
    wb_dat  = alu_res;
    case (opcode)
      OPC_LUI: begin
        rf_we  = 1'b1;
        wb_dat = imm_u;
      end
      OPC_AUIPC: begin
        rf_we  = 1'b1;
        wb_dat = pc_q + imm_u;
      end
      OPC_JAL: begin
        rf_we  = 1'b1;
        wb_dat = pc_plus4;
        pc_d   = pc_q + imm_j;
      end
      OPC_JALR: begin
        rf_we  = 1'b1;
        wb_dat = pc_plus4;
        pc_d   = alu_res & ~32'd1;
      end
      OPC_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
      OPC_LOAD: begin
        rf_we  = 1'b1;
        wb_dat = dmem_rdat;
      end
      OPC_STORE:  dmem_we = 1'b1;
      OPC_OP:     rf_we   = 1'b1;
      OPC_OP_IMM: rf_we   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end
endmodule

// File: tb/tb_sc_rv32i_datapath.sv
// Directed bench for sc_rv32i_datapath: programs are assembled in place, memories
// are preloaded hierarchically while reset is held, and results are hand-computed.

module tb_sc_rv32i_datapath;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sc_rv32i_datapath #(.IMEM_DEPTH(256), .DMEM_DEPTH(256), .RESET_PC(32'd0)) dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Tiny assembler
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(int op, int imm, int rs1, int f3, int rd);
    logic [31:0] im;
    im = imm;
    return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    logic [31:0] im;
    im = imm;
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int f3, int rs1, int rs2, int imm);
    logic [31:0] im;
    im = imm;
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(int rd, int imm);
    logic [31:0] im;
    im = imm;
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6F};
  endfunction
  function automatic logic [31:0] enc_u(int op, int imm20, int rd);
    logic [31:0] im;
    im = imm20;
    return {im[19:0], 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(19, imm, rs1, 0, rd);
  endfunction
  function automatic logic [31:0] lw(int rd, int imm, int rs1);
    return enc_i(3, imm, rs1, 2, rd);
  endfunction

  task automatic clear_state();
    for (int i = 0; i < 256; i++) begin
      dut.inst_mem_0.memory[i] = 32'h0000_0013;
      dut.data_mem_0.memory[i] = 32'd0;
    end
    for (int i = 0; i < 32; i++) dut.reg_file_0.registers[i] = 32'd0;
  endtask

  task automatic im(input int idx, input logic [31:0] w);
    dut.inst_mem_0.memory[idx] = w;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] xr(input int n);
    return dut.reg_file_0.registers[n];
  endfunction
  function automatic logic [31:0] dm(input int n);
    return dut.data_mem_0.memory[n];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Prologue instruction after a single reset edge
    @(negedge clk);
    reset = 1'b1;
    clear_state();
    dut.reg_file_0.registers[2] = 32'd100;
    im(0, 32'hFE01_0113);
    run(1);
    check_val("reset_pc", dut.pc_q, 32'd0);
    reset = 1'b0;
    run(1);
    check_val("t1_sp", xr(2), 32'd68);
    check_val("t1_pc", dut.pc_q, 32'd4);
    check_val("t1_x8", xr(8), 32'd0);
    run(1);

    // Reset held across several edges must block all writes
    reset = 1'b1;
    clear_state();
    dut.reg_file_0.registers[5] = 32'h55;
    dut.reg_file_0.registers[9] = 32'h99;
    dut.data_mem_0.memory[3] = 32'h33;
    im(0, enc_s(12, 5, 0));
    im(1, addi(1, 0, 7));
    run(4);
    check_val("t2_pc", dut.pc_q, 32'd0);
    check_val("t2_x1", xr(1), 32'd0);
    check_val("t2_x5", xr(5), 32'h55);
    check_val("t2_x9", xr(9), 32'h99);
    check_val("t2_dmem3", dm(3), 32'h33);
    reset = 1'b0;
    run(1);
    check_val("t2_dmem3_rel", dm(3), 32'h55);
    check_val("t2_pc_rel", dut.pc_q, 32'd4);
    run(1);
    check_val("t2_x1_rel", xr(1), 32'd7);

    // Stack-frame program with two loops
    reset = 1'b1;
    clear_state();
    dut.reg_file_0.registers[2] = 32'd100;
    dut.data_mem_0.memory[2]  = 32'd20;
    dut.data_mem_0.memory[18] = 32'd55;
    dut.data_mem_0.memory[22] = 32'd44;
    dut.data_mem_0.memory[24] = 32'd99;
    dut.data_mem_0.memory[28] = 32'd77;
    im(0,  addi(2, 2, -32));
    im(1,  enc_s(44, 8, 2));
    im(2,  addi(8, 2, 48));
    im(3,  addi(15, 0, 5));
    im(4,  enc_s(-32, 15, 8));
    im(5,  addi(15, 0, 10));
    im(6,  enc_s(-36, 15, 8));
    im(7,  lw(14, -32, 8));
    im(8,  lw(15, -36, 8));
    im(9,  enc_r(0, 15, 14, 0, 15));
    im(10, enc_s(-40, 15, 8));
    im(11, enc_r(0, 15, 15, 0, 15));
    im(12, enc_s(-24, 15, 8));
    im(13, enc_s(-44, 0, 8));
    im(14, enc_s(-28, 0, 8));
    im(15, lw(15, -28, 8));
    im(16, addi(15, 15, 1));
    im(17, enc_s(-28, 15, 8));
    im(18, lw(15, -44, 8));
    im(19, addi(15, 15, 1));
    im(20, enc_s(-44, 15, 8));
    im(21, addi(14, 0, 10));
    im(22, enc_b(4, 15, 14, -28));
    im(23, lw(15, -36, 8));
    im(24, addi(15, 15, -5));
    im(25, enc_b(4, 0, 15, -4));
    im(26, enc_s(-20, 15, 8));
    im(27, enc_j(0, 52));
    for (int i = 28; i < 40; i++) im(i, enc_s(8, 0, 0));
    im(40, enc_j(0, 0));
    run(1);
    reset = 1'b0;
    run(150);
    check_val("t3_d21", dm(21), 32'd5);
    check_val("t3_d20", dm(20), 32'd10);
    check_val("t3_d19", dm(19), 32'd15);
    check_val("t3_d18", dm(18), 32'd10);
    check_val("t3_d22", dm(22), 32'd10);
    check_val("t3_d23", dm(23), 32'd30);
    check_val("t3_d24", dm(24), 32'd0);
    check_val("t3_d28", dm(28), 32'd0);
    check_val("t3_d2", dm(2), 32'd20);
    check_val("t3_sp", xr(2), 32'd68);
    check_val("t3_s0", xr(8), 32'd116);
    check_val("t3_pc", dut.pc_q, 32'd160);
    run(5);
    check_val("t3_pc_hold", dut.pc_q, 32'd160);

    // Branch conditions, signed versus unsigned
    reset = 1'b1;
    clear_state();
    im(0,  addi(14, 0, 0));
    im(1,  addi(15, 0, 10));
    im(2,  enc_b(4, 14, 15, 8));
    im(3,  addi(20, 0, 1));
    im(4,  enc_b(5, 14, 15, 8));
    im(5,  addi(21, 0, 1));
    im(6,  addi(16, 0, -1));
    im(7,  addi(17, 0, 1));
    im(8,  enc_b(4, 16, 17, 8));
    im(9,  addi(22, 0, 1));
    im(10, enc_b(6, 16, 17, 8));
    im(11, addi(23, 0, 1));
    im(12, enc_b(7, 16, 17, 8));
    im(13, addi(24, 0, 1));
    im(14, enc_b(0, 14, 0, 8));
    im(15, addi(25, 0, 1));
    im(16, enc_b(1, 14, 0, 8));
    im(17, addi(26, 0, 1));
    im(18, enc_j(0, 0));
    run(1);
    reset = 1'b0;
    run(30);
    check_val("t4_blt_taken", xr(20), 32'd0);
    check_val("t4_bge_not", xr(21), 32'd1);
    check_val("t4_blt_signed", xr(22), 32'd0);
    check_val("t4_bltu_not", xr(23), 32'd1);
    check_val("t4_bgeu_taken", xr(24), 32'd0);
    check_val("t4_beq_taken", xr(25), 32'd0);
    check_val("t4_bne_not", xr(26), 32'd1);
    check_val("t4_pc", dut.pc_q, 32'd72);

    // x0 stays zero
    reset = 1'b1;
    clear_state();
    im(0, addi(0, 0, 5));
    im(1, addi(6, 0, 3));
    run(1);
    reset = 1'b0;
    run(2);
    check_val("t5_x0", xr(0), 32'd0);
    check_val("t5_x6", xr(6), 32'd3);

    // jal / jalr link and target
    reset = 1'b1;
    clear_state();
    im(0, enc_j(1, 8));
    im(1, enc_u(55, 32'h12345, 7));
    im(2, enc_i(103, 0, 1, 0, 0));
    run(1);
    reset = 1'b0;
    run(1);
    check_val("t6_jal_link", xr(1), 32'd4);
    check_val("t6_jal_pc", dut.pc_q, 32'd8);
    run(1);
    check_val("t6_jalr_pc", dut.pc_q, 32'd4);
    run(1);
    check_val("t6_lui", xr(7), 32'h1234_5000);

    // ALU coverage, unknown opcode, wrapped data address
    reset = 1'b1;
    clear_state();
    dut.reg_file_0.registers[5]  = 32'h8000_0010;
    dut.reg_file_0.registers[6]  = 32'd4;
    dut.reg_file_0.registers[7]  = 32'd36;
    dut.reg_file_0.registers[26] = 32'd1031;
    dut.reg_file_0.registers[31] = 32'h5A5A;
    im(0,  enc_r(32, 6, 5, 0, 10));
    im(1,  enc_r(0, 6, 5, 1, 11));
    im(2,  enc_r(32, 6, 5, 5, 12));
    im(3,  enc_r(0, 6, 5, 5, 13));
    im(4,  enc_r(0, 6, 5, 2, 14));
    im(5,  enc_r(0, 6, 5, 3, 15));
    im(6,  enc_r(0, 6, 5, 4, 16));
    im(7,  enc_r(0, 6, 5, 6, 17));
    im(8,  enc_r(0, 6, 5, 7, 18));
    im(9,  enc_i(19, 32'h401, 5, 5, 19));
    im(10, enc_i(19, -1, 6, 3, 20));
    im(11, enc_i(19, -16, 5, 7, 21));
    im(12, enc_u(23, 1, 22));
    im(13, enc_u(55, 32'hABCDE, 23));
    im(14, enc_i(19, 29, 6, 1, 24));
    im(15, enc_r(0, 7, 6, 1, 25));
    im(16, 32'hFFFF_FFFF);
    im(17, enc_s(0, 5, 26));
    im(18, lw(27, 4, 0));
    im(19, enc_r(0, 5, 5, 0, 28));
    im(20, enc_j(0, 0));
    run(1);
    reset = 1'b0;
    run(30);
    check_val("alu_sub", xr(10), 32'h8000_000C);
    check_val("alu_sll", xr(11), 32'h0000_0100);
    check_val("alu_sra", xr(12), 32'hF800_0001);
    check_val("alu_srl", xr(13), 32'h0800_0001);
    check_val("alu_slt", xr(14), 32'd1);
    check_val("alu_sltu", xr(15), 32'd0);
    check_val("alu_xor", xr(16), 32'h8000_0014);
    check_val("alu_or", xr(17), 32'h8000_0014);
    check_val("alu_and", xr(18), 32'd0);
    check_val("alu_srai", xr(19), 32'hC000_0008);
    check_val("alu_sltiu", xr(20), 32'd1);
    check_val("alu_andi", xr(21), 32'h8000_0010);
    check_val("alu_auipc", xr(22), 32'h0000_1030);
    check_val("alu_lui", xr(23), 32'hABCD_E000);
    check_val("alu_slli", xr(24), 32'h8000_0000);
    check_val("alu_shamt5", xr(25), 32'h0000_0040);
    check_val("unknown_nop", xr(31), 32'h5A5A);
    check_val("sw_wrap", dm(1), 32'h8000_0010);
    check_val("lw_wrap", xr(27), 32'h8000_0010);
    check_val("add_wrap", xr(28), 32'h0000_0020);
    check_val("alu_pc", dut.pc_q, 32'd80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
